// File: rtl/cmd_decoder.sv
// rtl/cmd_decoder.sv - rx frame parser with packet buffer and sink replay; CMD_DEC_CRC_CHECK_EN enables CRC compare
module cmd_decoder #(
    parameter int         N_DST   = 4,
    parameter int         MAX_LEN = 255,
    parameter int         TIMEOUT = 65535,
    parameter logic [7:0] PREFIX  = 8'hA5
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [7:0]       wr_data,
    output logic [N_DST-1:0] wrreq_bus,
    input  logic [N_DST-1:0] full_bus,
    output logic             pkt_ok,
    output logic             err_valid,
    output logic [2:0]       err_code,
    output logic             busy
);

    localparam int DW = (N_DST > 1) ? $clog2(N_DST) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [7:0]    N_DST_B  = 8'(N_DST);
    localparam logic [7:0]    MAX_B    = 8'(MAX_LEN);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, GET_DST, GET_LEN, GET_DATA, GET_CRC, FLUSH
    } state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     dst_q, dst_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        rd_q, rd_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [N_DST-1:0]  wrreq_q, wrreq_d;
    logic              pkt_ok_q, pkt_ok_d;
    logic              err_valid_q, err_valid_d;
    logic [2:0]        err_code_q, err_code_d;
    logic              buf_we;
    logic [7:0]        buf_q [MAX_LEN];
`ifdef CMD_DEC_CRC_CHECK_EN
    logic [7:0]        crc_q, crc_d;
`endif

    always_comb begin
        state_d     = state_q;
        dst_d       = dst_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        rd_d        = rd_q;
        tmo_d       = '0;
        wr_data_d   = wr_data_q;
        wrreq_d     = '0;
        pkt_ok_d    = 1'b0;
        err_valid_d = 1'b0;
        err_code_d  = err_code_q;
        buf_we      = 1'b0;
`ifdef CMD_DEC_CRC_CHECK_EN
        crc_d       = crc_q;
`endif
        case (state_q)
            IDLE: begin
                if (rx_valid && rx_data == PREFIX) state_d = GET_DST;
            end
            FLUSH: begin
                if (rx_valid) begin
                    err_valid_d = 1'b1;
                    err_code_d  = 3'd4;
                end
                // rd_q == len_q means the last byte went out on the previous edge
                if (rd_q == len_q) begin
                    state_d = IDLE;
                end else if (!full_bus[dst_q]) begin
                    wr_data_d      = buf_q[rd_q];
                    wrreq_d[dst_q] = 1'b1;
                    rd_d           = rd_q + 8'd1;
                end
            end
            default: begin
                if (rx_valid) begin
                    case (state_q)
                        GET_DST: begin
                            dst_d = rx_data[DW-1:0];
`ifdef CMD_DEC_CRC_CHECK_EN
                            crc_d = rx_data;
`endif
                            if (rx_data >= N_DST_B) begin
                                err_valid_d = 1'b1;
                                err_code_d  = 3'd3;
                                state_d     = IDLE;
                            end else begin
                                state_d = GET_LEN;
                            end
                        end
                        GET_LEN: begin
                            len_d = rx_data;
`ifdef CMD_DEC_CRC_CHECK_EN
                            crc_d = crc_q + rx_data;
`endif
                            if (rx_data == 8'd0 || rx_data > MAX_B) begin
                                err_valid_d = 1'b1;
                                err_code_d  = 3'd2;
                                state_d     = IDLE;
                            end else begin
                                cnt_d   = 8'd0;
                                state_d = GET_DATA;
                            end
                        end
                        GET_DATA: begin
                            buf_we = 1'b1;
`ifdef CMD_DEC_CRC_CHECK_EN
                            crc_d  = crc_q + rx_data;
`endif
                            cnt_d  = cnt_q + 8'd1;
                            if (cnt_q + 8'd1 == len_q) state_d = GET_CRC;
                        end
                        default: begin
`ifdef CMD_DEC_CRC_CHECK_EN
                            if (rx_data == crc_q) begin
                                pkt_ok_d = 1'b1;
                                rd_d     = 8'd0;
                                state_d  = FLUSH;
                            end else begin
                                err_valid_d = 1'b1;
                                err_code_d  = 3'd1;
                                state_d     = IDLE;
                            end
`else
                            pkt_ok_d = 1'b1;
                            rd_d     = 8'd0;
                            state_d  = FLUSH;
`endif
                        end
                    endcase
                end else if (tmo_q == TMO_LAST) begin
                    err_valid_d = 1'b1;
                    err_code_d  = 3'd5;
                    state_d     = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            dst_q       <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            rd_q        <= '0;
            tmo_q       <= '0;
            wr_data_q   <= '0;
            wrreq_q     <= '0;
            pkt_ok_q    <= 1'b0;
            err_valid_q <= 1'b0;
            err_code_q  <= '0;
`ifdef CMD_DEC_CRC_CHECK_EN
            crc_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            dst_q       <= dst_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            rd_q        <= rd_d;
            tmo_q       <= tmo_d;
            wr_data_q   <= wr_data_d;
            wrreq_q     <= wrreq_d;
            pkt_ok_q    <= pkt_ok_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
`ifdef CMD_DEC_CRC_CHECK_EN
            crc_q       <= crc_d;
`endif
        end
    end

    // Packet buffer keeps its contents across reset
    always_ff @(posedge clk) begin
        if (buf_we) buf_q[cnt_q] <= rx_data;
    end

    assign wr_data   = wr_data_q;
    assign wrreq_bus = wrreq_q;
    assign pkt_ok    = pkt_ok_q;
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cmd_decoder.sv
// tb/tb_cmd_decoder.sv - event-queue model bench for cmd_decoder
module tb_cmd_decoder;
    localparam int         N_DST   = 4;
    localparam int         MAX_LEN = 8;
    localparam int         TIMEOUT = 20;
    localparam logic [7:0] PREFIX  = 8'hA5;

    typedef logic [7:0] bq_t[$];

    logic             clk = 1'b0;
    logic             n_rst = 1'b0;
    logic [7:0]       rx_data = 8'h00;
    logic             rx_valid = 1'b0;
    logic [7:0]       wr_data;
    logic [N_DST-1:0] wrreq_bus;
    logic [N_DST-1:0] full_bus = '0;
    logic             pkt_ok;
    logic             err_valid;
    logic [2:0]       err_code;
    logic             busy;

    cmd_decoder #(.N_DST(N_DST), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT), .PREFIX(PREFIX)) dut (
        .clk(clk), .n_rst(n_rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .wr_data(wr_data), .wrreq_bus(wrreq_bus), .full_bus(full_bus),
        .pkt_ok(pkt_ok), .err_valid(err_valid), .err_code(err_code), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_ev[$];      // 0 = pkt_ok, 1..5 = err_code
    int exp_wr[$];      // dst*256 + data
    int ok_log[$];
    int wr_cyc_log[$];
    int wr_dat_log[$];
    int wr_bus_log[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (n_rst) begin
            if (pkt_ok && err_valid) chk("ok_err_mutex", 1, 0);
            if (pkt_ok) begin
                ok_log.push_back(cyc);
                if (exp_ev.size() == 0) chk("unexpected_pkt_ok", 0, 1);
                else chk("event_ok", 0, exp_ev.pop_front());
            end
            if (err_valid) begin
                if (exp_ev.size() == 0) chk("unexpected_err", int'(err_code), -1);
                else chk("event_err", int'(err_code), exp_ev.pop_front());
            end
            if (wrreq_bus != '0) begin
                int e;
                chk("wrreq_onehot", int'($onehot(wrreq_bus)), 1);
                chk("wrreq_busy", int'(busy), 1);
                wr_cyc_log.push_back(cyc);
                wr_dat_log.push_back(int'(wr_data));
                wr_bus_log.push_back(int'(wrreq_bus));
                if (exp_wr.size() == 0) begin
                    chk("unexpected_wrreq", int'(wrreq_bus), 0);
                end else begin
                    e = exp_wr.pop_front();
                    chk("wr_dst", int'(wrreq_bus), 1 << (e >> 8));
                    chk("wr_data", int'(wr_data), e & 255);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Model: decides the frame outcome from the framing rules before sending it.
    task automatic send_frame(input int dst, input int len, input bq_t pl, input int crc_delta);
        int sum;
        int crc;
        sum = dst + len;
        foreach (pl[i]) sum += int'(pl[i]);
        sum = sum & 255;
        crc = (sum + crc_delta) & 255;
        if (dst >= N_DST) begin
            exp_ev.push_back(3);
            send_byte(PREFIX);
            send_byte(8'(dst));
            return;
        end
        if (len == 0 || len > MAX_LEN) begin
            exp_ev.push_back(2);
            send_byte(PREFIX);
            send_byte(8'(dst));
            send_byte(8'(len));
            return;
        end
`ifdef CMD_DEC_CRC_CHECK_EN
        if (crc != sum) begin
            exp_ev.push_back(1);
        end else begin
            exp_ev.push_back(0);
            foreach (pl[i]) exp_wr.push_back(dst * 256 + int'(pl[i]));
        end
`else
        exp_ev.push_back(0);
        foreach (pl[i]) exp_wr.push_back(dst * 256 + int'(pl[i]));
`endif
        send_byte(PREFIX);
        send_byte(8'(dst));
        send_byte(8'(len));
        foreach (pl[i]) send_byte(pl[i]);
        send_byte(8'(crc));
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((busy || exp_wr.size() != 0 || exp_ev.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({"idle_", name}, int'(n < budget), 1);
        @(negedge clk);
    endtask

    task automatic wait_writes(input int bit_idx, input int want);
        int n = 0;
        int k = 0;
        while (n < want && k < 50) begin
            @(negedge clk);
            if (wrreq_bus[bit_idx]) n++;
            k++;
        end
        chk("wait_writes", n, want);
    endtask

    initial begin
        bq_t pl;
        int k;
        repeat (3) @(negedge clk);
        chk("rst_wr_data", int'(wr_data), 0);
        chk("rst_wrreq", int'(wrreq_bus), 0);
        chk("rst_pkt_ok", int'(pkt_ok), 0);
        chk("rst_err_valid", int'(err_valid), 0);
        chk("rst_err_code", int'(err_code), 0);
        chk("rst_busy", int'(busy), 0);
        n_rst = 1'b1;
        @(negedge clk);

        // Good frame: literal timing and data
        ok_log.delete(); wr_cyc_log.delete(); wr_dat_log.delete(); wr_bus_log.delete();
        pl = '{8'h10, 8'h20, 8'h30};
        send_frame(1, 3, pl, 0);
        wait_idle("good", 30);
        chk("good_ok_count", ok_log.size(), 1);
        chk("good_wr_count", wr_dat_log.size(), 3);
        if (wr_dat_log.size() == 3 && ok_log.size() == 1) begin
            chk("good_d0", wr_dat_log[0], 'h10);
            chk("good_d1", wr_dat_log[1], 'h20);
            chk("good_d2", wr_dat_log[2], 'h30);
            chk("good_bus", wr_bus_log[0], 'b0010);
            chk("good_first_after_ok", int'(wr_cyc_log[0] > ok_log[0]), 1);
            chk("good_consec", wr_cyc_log[2] - wr_cyc_log[0], 2);
        end
        chk("good_no_err", int'(err_code), 0);

        // Bad CRC
        pl = '{8'h10, 8'h20, 8'h30};
        send_frame(1, 3, pl, 1);
`ifdef CMD_DEC_CRC_CHECK_EN
        chk("badcrc_busy", int'(busy), 0);
        chk("badcrc_code", int'(err_code), 1);
`endif
        wait_idle("badcrc", 30);

        // Destination and length errors, then a good frame to sink 0
        pl = '{8'h01};
        send_frame(4, 1, pl, 0);
        chk("dst_code", int'(err_code), 3);
        send_frame(2, 0, pl, 0);
        chk("len0_code", int'(err_code), 2);
        send_frame(2, 9, pl, 0);
        chk("len9_code", int'(err_code), 2);
        pl = '{8'hA5, 8'h5A};
        send_frame(0, 2, pl, 0);
        wait_idle("dst0", 30);

        // Backpressure on sink 2 after two bytes
        pl = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(2, 4, pl, 0);
        wait_writes(2, 2);
        full_bus[2] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_wrreq", int'(wrreq_bus), 0);
            chk("stall_hold", int'(wr_data), 'h22);
        end
        full_bus[2] = 1'b0;
        wait_idle("bp", 30);

        // Overrun: a PREFIX during flush is lost and flagged
        pl = '{8'h01, 8'h02, 8'h03};
        send_frame(3, 3, pl, 0);
        exp_ev.push_back(4);
        send_byte(PREFIX);
        wait_idle("overrun", 30);
        chk("overrun_code", int'(err_code), 4);
        chk("overrun_not_busy", int'(busy), 0);

        // Timeout after the len byte
        exp_ev.push_back(5);
        send_byte(PREFIX);
        send_byte(8'h01);
        send_byte(8'h02);
        k = 0;
        while (!err_valid && k < TIMEOUT + 3) begin
            @(negedge clk);
            k++;
        end
        chk("tmo_window", int'(k >= TIMEOUT - 1 && k <= TIMEOUT + 2), 1);
        chk("tmo_code", int'(err_code), 5);
        chk("tmo_busy", int'(busy), 0);
        wait_idle("tmo", 30);

        // Reset mid-flush after 2 of 4 bytes
        pl = '{8'h05, 8'h06, 8'h07, 8'h08};
        send_frame(1, 4, pl, 0);
        wait_writes(1, 2);
        #2;
        n_rst = 1'b0;
        #1;
        chk("rst_mid_wrreq", int'(wrreq_bus), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_dropped", exp_wr.size(), 2);
        exp_wr.delete();
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_code", int'(err_code), 0);
        pl = '{8'hC0, 8'hDE};
        send_frame(1, 2, pl, 0);
        wait_idle("after_rst", 30);

        chk("end_ev_empty", exp_ev.size(), 0);
        chk("end_wr_empty", exp_wr.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end
endmodule
